sd_card_cmd_responder: RTL and testbench
========================================

Name: sd_card_cmd_responder

Overview:
- Card-side end of the SD command path; answers the host command controller.
- Accepts a 38-bit command word from the card PHY over a four-phase strobe/ack handshake and decodes index and argument.
- After a programmable response delay (NCR), returns a 38-bit response word to the PHY over the same handshake, with ack-timeout supervision.

Parameters:
- RESP_DELAY, 4, idle cycles between command ack release and response strobe (NCR); legal range 1..255.
- ACK_TIMEOUT, 64, cycles to wait for each host ack edge before aborting; legal range 1..65535.
- MAX_INDEX, 55, highest legal command index; indices above it are illegal.

Ports:
- iClock_host  input  1  single clock, rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iStrobe_in  input  1  command valid from PHY.
- iCmd_in  input  38  command word: [37:32] index, [31:0] argument.
- oAck_out  output  1  command accepted.
- oCmd_out  output  38  response word.
- oStrobe_out  output  1  response valid.
- iAck_in  input  1  response accepted by PHY.
- oIdle_out  output  1  high only in IDLE.
- oCommand_complete  output  1  one-cycle pulse on transaction end.
- oCommand_index_error  output  1  latched high when the last command was illegal.
- oTimeout_error  output  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset (async): state IDLE, oIdle_out=1, all other outputs 0, command counter 0, internal timers 0.
- IDLE: on iStrobe_in=1, latch iCmd_in, clear oCommand_index_error, go to CMD_ACK. oAck_out=1 from the next cycle.
- CMD_ACK: hold oAck_out=1 until iStrobe_in=0, then drop oAck_out the following cycle.
  - Index 0 (GO_IDLE): no response. Pulse oCommand_complete, return to IDLE, clear counter.
  - Any other index: go to WAIT_NCR.
- Index legality: index > MAX_INDEX is illegal, including 6'h3F. Set oCommand_index_error=1 (held until next command accept); a response is still sent.
- WAIT_NCR: count exactly RESP_DELAY cycles, load oCmd_out, go to RESP_STB.
  - oCmd_out[37:32] = echoed index.
  - oCmd_out[31:16] = argument[15:0].
  - oCmd_out[15:8] = 8-bit command counter (post-increment value; counts legal responded commands, wraps 255->0).
  - oCmd_out[7:1] = 0.
  - oCmd_out[0] = illegal flag.
- RESP_STB: oStrobe_out=1, oCmd_out stable. On iAck_in=1, drop oStrobe_out next cycle and go to RESP_REL.
- RESP_REL: wait for iAck_in=0, then pulse oCommand_complete and return to IDLE. oCmd_out holds its value until the next load.
- Timeout: a counter runs in CMD_ACK, RESP_STB and RESP_REL and restarts at each state entry. On reaching ACK_TIMEOUT:
  - pulse oTimeout_error;
  - clear oAck_out and oStrobe_out;
  - return to IDLE; no oCommand_complete.
- iStrobe_in high outside IDLE is ignored. iAck_in high outside RESP_STB/RESP_REL is ignored.
- Reset mid-transaction: immediate return to the reset state. No complete or timeout pulse.
- Latency: iStrobe_in rise to oAck_out rise = 1 cycle. Ack release to oStrobe_out = RESP_DELAY+1 cycles.

Optional Feature:
- Macro: SD_CARD_RESP_CRC7_EN.
- Defined: adds output oResp_crc7 [6:0], the CRC7 (poly x^7+x^3+1, init 0) over the 40-bit frame {1'b0,1'b0,oCmd_out}, MSB first. Registered in the same cycle as oCmd_out; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Legal command: iCmd_in={6'd17,32'h0000ABCD}, full handshake, RESP_DELAY=4 -> oAck_out 1 cycle after strobe; oStrobe_out 5 cycles after ack release; oCmd_out={6'd17,16'hABCD,8'd1,8'h00}; one oCommand_complete pulse.
- Illegal index: iCmd_in={6'h3F,32'd5} -> oCommand_index_error=1; response {6'h3F,16'h0005,8'd0,8'h01}; counter not incremented.
- GO_IDLE: iCmd_in={6'd0,32'hFF} after two legal commands -> ack only, no oStrobe_out, oCommand_complete pulse; next legal response shows counter 1.
- Ack timeout: ACK_TIMEOUT=64, iAck_in held 0 in RESP_STB -> oTimeout_error pulse exactly 64 cycles after oStrobe_out rise; oStrobe_out=0; oIdle_out=1; no complete pulse.
- Reset mid-operation: assert iReset during WAIT_NCR -> all outputs 0 and oIdle_out=1 asynchronously; next command handled normally with counter restarted at 1.
- Counter wrap (with SD_CARD_RESP_CRC7_EN): 256 legal commands -> counter field wraps to 8'h00; oResp_crc7 matches the reference model for each response.

Source files
------------

// File: rtl/sd_card_cmd_responder_if.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder_if
// Command/response handshake bundle between the card PHY and the SD card
// command responder. Both directions use a four-phase strobe/ack handshake.
//
// Signals:
//   iStrobe_in   PHY -> responder  command valid
//   iCmd_in      PHY -> responder  38-bit command word ([37:32] index, [31:0] arg)
//   oAck_out     responder -> PHY  command accepted
//   oCmd_out     responder -> PHY  38-bit response word
//   oStrobe_out  responder -> PHY  response valid
//   iAck_in      PHY -> responder  response accepted
//
// Modports: master = PHY side, slave = responder side.
// -----------------------------------------------------------------------------
interface sd_card_cmd_responder_if;
  logic        iStrobe_in;
  logic [37:0] iCmd_in;
  logic        oAck_out;
  logic [37:0] oCmd_out;
  logic        oStrobe_out;
  logic        iAck_in;

  modport master (
    output iStrobe_in, iCmd_in, iAck_in,
    input  oAck_out, oCmd_out, oStrobe_out
  );

  modport slave (
    input  iStrobe_in, iCmd_in, iAck_in,
    output oAck_out, oCmd_out, oStrobe_out
  );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder
// Card-side end of the SD command path. Accepts a command word from the PHY,
// decodes index and argument, waits NCR (RESP_DELAY) cycles and returns a
// response word over the same four-phase handshake. Every host ack edge is
// supervised by an ACK_TIMEOUT-cycle watchdog.
//
// Ports:
//   iClock_host           clock, rising edge
//   iReset                asynchronous active-high reset
//   cmdBus                handshake bundle (slave modport)
//   oIdle_out             high only while idle
//   oCommand_complete     one-cycle pulse at normal transaction end
//   oCommand_index_error  held high while the last accepted index was illegal
//   oTimeout_error        one-cycle pulse when an ack edge never arrives
//   oResp_crc7            CRC7 of {2'b00, oCmd_out} (only with the macro below)
//
// Optional feature: define SD_CARD_RESP_CRC7_EN to add oResp_crc7.
//
// Response word: {index, arg[15:0], count[7:0], 7'b0, illegal}. The count is
// the number of legal responded commands (post-increment, wraps at 8 bits);
// GO_IDLE (index 0) gets no response and clears it.
// -----------------------------------------------------------------------------
module sd_card_cmd_responder #(
  parameter int unsigned RESP_DELAY  = 4,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned MAX_INDEX   = 55
) (
  input  logic                   iClock_host,
  input  logic                   iReset,
  sd_card_cmd_responder_if.slave cmdBus,
  output logic                   oIdle_out,
  output logic                   oCommand_complete,
  output logic                   oCommand_index_error,
  output logic                   oTimeout_error
`ifdef SD_CARD_RESP_CRC7_EN
  ,
  output logic [6:0]             oResp_crc7
`endif
);

  localparam logic [7:0]  DELAY_LAST = 8'(RESP_DELAY - 1);
  localparam logic [15:0] TIMER_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [5:0]  MAX_IDX    = 6'(MAX_INDEX);

  typedef enum logic [2:0] {
    IDLE,
    CMD_ACK,
    WAIT_NCR,
    RESP_STB,
    RESP_REL
  } stateT;

  stateT       state;
  logic [5:0]  cmdIndex;
  logic [15:0] cmdArgLow;
  logic [7:0]  respCount;
  logic [7:0]  delayCount;
  logic [15:0] ackTimer;

  logic [7:0]  respCountNext;
  logic [37:0] respWord;
  logic        timerDone;

`ifdef SD_CARD_RESP_CRC7_EN
  // MSB-first CRC7, poly x^7+x^3+1, init 0.
  function automatic logic [6:0] crc7Frame(input logic [39:0] frame);
    logic [6:0] crc;
    logic       feedback;
    // NOTE: blocking assignments inside a function model a chain of gates
    // evaluated in order; no state is created.
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      feedback = frame[i] ^ crc[6];
      crc      = {crc[5:0], 1'b0};
      if (feedback) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction
`endif

  // Response assembly. The illegal flag is the held index-error output, which
  // is rewritten only when a new command is accepted.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    respCountNext = oCommand_index_error ? respCount : respCount + 8'd1;
    respWord      = {cmdIndex, cmdArgLow, respCountNext, 7'd0, oCommand_index_error};
  end

  assign timerDone = (ackTimer == TIMER_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iClock_host or posedge iReset) begin
    if (iReset) begin
      state                <= IDLE;
      cmdBus.oAck_out      <= 1'b0;
      cmdBus.oStrobe_out   <= 1'b0;
      cmdBus.oCmd_out      <= '0;
      oIdle_out            <= 1'b1;
      oCommand_complete    <= 1'b0;
      oCommand_index_error <= 1'b0;
      oTimeout_error       <= 1'b0;
      cmdIndex             <= '0;
      cmdArgLow            <= '0;
      respCount            <= '0;
      delayCount           <= '0;
      ackTimer             <= '0;
`ifdef SD_CARD_RESP_CRC7_EN
      oResp_crc7           <= '0;
`endif
    end else begin
      oCommand_complete <= 1'b0;
      oTimeout_error    <= 1'b0;

      case (state)
        IDLE: begin
          if (cmdBus.iStrobe_in) begin
            cmdIndex             <= cmdBus.iCmd_in[37:32];
            cmdArgLow            <= cmdBus.iCmd_in[15:0];
            oCommand_index_error <= (cmdBus.iCmd_in[37:32] > MAX_IDX);
            cmdBus.oAck_out      <= 1'b1;
            oIdle_out            <= 1'b0;
            ackTimer             <= '0;
            state                <= CMD_ACK;
          end
        end

        CMD_ACK: begin
          if (!cmdBus.iStrobe_in) begin
            cmdBus.oAck_out <= 1'b0;
            if (cmdIndex == 6'd0) begin
              // GO_IDLE: no response, counter restarts.
              respCount         <= '0;
              oCommand_complete <= 1'b1;
              oIdle_out         <= 1'b1;
              state             <= IDLE;
            end else begin
              delayCount <= '0;
              state      <= WAIT_NCR;
            end
          end else if (timerDone) begin
            cmdBus.oAck_out <= 1'b0;
            oTimeout_error  <= 1'b1;
            oIdle_out       <= 1'b1;
            state           <= IDLE;
          end else begin
            ackTimer <= ackTimer + 16'd1;
          end
        end

        WAIT_NCR: begin
          if (delayCount == DELAY_LAST) begin
            cmdBus.oCmd_out    <= respWord;
            respCount          <= respCountNext;
            cmdBus.oStrobe_out <= 1'b1;
            ackTimer           <= '0;
            state              <= RESP_STB;
`ifdef SD_CARD_RESP_CRC7_EN
            oResp_crc7         <= crc7Frame({2'b00, respWord});
`endif
          end else begin
            delayCount <= delayCount + 8'd1;
          end
        end

        RESP_STB: begin
          if (cmdBus.iAck_in) begin
            cmdBus.oStrobe_out <= 1'b0;
            ackTimer           <= '0;
            state              <= RESP_REL;
          end else if (timerDone) begin
            cmdBus.oStrobe_out <= 1'b0;
            oTimeout_error     <= 1'b1;
            oIdle_out          <= 1'b1;
            state              <= IDLE;
          end else begin
            ackTimer <= ackTimer + 16'd1;
          end
        end

        RESP_REL: begin
          if (!cmdBus.iAck_in) begin
            oCommand_complete <= 1'b1;
            oIdle_out         <= 1'b1;
            state             <= IDLE;
          end else if (timerDone) begin
            oTimeout_error <= 1'b1;
            oIdle_out      <= 1'b1;
            state          <= IDLE;
          end else begin
            ackTimer <= ackTimer + 16'd1;
          end
        end

        default: begin
          cmdBus.oAck_out    <= 1'b0;
          cmdBus.oStrobe_out <= 1'b0;
          oIdle_out          <= 1'b1;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_sd_card_cmd_responder
// Self-checking bench for sd_card_cmd_responder. A transaction-level model
// keeps the expected counter and response word; a negedge monitor compares
// the response bus against it whenever oStrobe_out is high, and the driver
// checks handshake latencies, pulses and timeouts per transaction.
// -----------------------------------------------------------------------------
module tb_sd_card_cmd_responder;

  localparam int RESP_DELAY  = 4;
  localparam int ACK_TIMEOUT = 64;
  localparam int MAX_INDEX   = 55;

  logic iClock_host;
  logic iReset;
  logic oIdle_out;
  logic oCommand_complete;
  logic oCommand_index_error;
  logic oTimeout_error;
`ifdef SD_CARD_RESP_CRC7_EN
  logic [6:0] oResp_crc7;
`endif

  sd_card_cmd_responder_if bus();

  sd_card_cmd_responder #(
    .RESP_DELAY (RESP_DELAY),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_INDEX  (MAX_INDEX)
  ) dut (
    .iClock_host         (iClock_host),
    .iReset              (iReset),
    .cmdBus              (bus),
    .oIdle_out           (oIdle_out),
    .oCommand_complete   (oCommand_complete),
    .oCommand_index_error(oCommand_index_error),
    .oTimeout_error      (oTimeout_error)
`ifdef SD_CARD_RESP_CRC7_EN
    ,
    .oResp_crc7          (oResp_crc7)
`endif
  );

  initial iClock_host = 1'b0;
  always #5 iClock_host = ~iClock_host;

  int total = 0;
  int bad   = 0;

  // Model state: legal-response counter and the response currently expected.
  logic [7:0]  modelCount = 8'd0;
  logic [37:0] expResp    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC7 as polynomial long division of frame*x^7 by x^7+x^3+1.
  function automatic logic [6:0] refCrc7(input logic [39:0] frame);
    logic [46:0] r;
    r = {frame, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Response monitor.
  always @(negedge iClock_host) begin
    if (!iReset && bus.oStrobe_out) begin
      check("mon_resp_word", bus.oCmd_out, expResp);
`ifdef SD_CARD_RESP_CRC7_EN
      check("mon_resp_crc7", oResp_crc7, refCrc7({2'b00, expResp}));
`endif
    end
  end

  // One full transaction. mode: 0 normal, 1 never ack the response,
  // 2 never release the response ack, 3 never release the command strobe.
  // Entered and left just after a rising edge.
  task automatic runCmd(input logic [5:0] idx, input logic [31:0] arg, input int mode,
                        output logic [37:0] resp);
    logic       illegal;
    logic [7:0] nextCount;
    int         n;
    int         strobeSeen;
    logic       sawComplete;

    resp      = '0;
    illegal   = (idx > 6'(MAX_INDEX));
    nextCount = illegal ? modelCount : modelCount + 8'd1;
    if (mode != 3 && idx != 6'd0) expResp = {idx, arg[15:0], nextCount, 7'd0, illegal};

    check("idle_before_cmd", oIdle_out, 1);
    bus.iCmd_in    = {idx, arg};
    bus.iStrobe_in = 1'b1;
    n = 0;
    do begin @(posedge iClock_host); #1; n++; end while (!bus.oAck_out && n < 20);
    check("cmd_ack_latency", n, 1);
    check("index_error", oCommand_index_error, illegal);
    check("busy_not_idle", oIdle_out, 0);

    if (mode == 3) begin
      n = 0; sawComplete = 0;
      do begin
        @(posedge iClock_host); #1; n++;
        if (oCommand_complete) sawComplete = 1;
      end while (!oTimeout_error && n < 200);
      bus.iStrobe_in = 1'b0;
      check("cmd_ack_timeout_cycles", n, ACK_TIMEOUT);
      check("cmd_ack_timeout_ack", bus.oAck_out, 0);
      check("cmd_ack_timeout_idle", oIdle_out, 1);
      check("cmd_ack_timeout_nocomplete", sawComplete, 0);
      return;
    end

    for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
      @(posedge iClock_host); #1;
    end
    bus.iStrobe_in = 1'b0;
    n = 0;
    do begin
      @(posedge iClock_host); #1; n++;
      if (n == 1) begin
        check("cmd_ack_release", bus.oAck_out, 0);
        if (idx == 6'd0) begin
          check("go_idle_complete", oCommand_complete, 1);
          check("go_idle_idle", oIdle_out, 1);
        end
      end
    end while (idx != 6'd0 && !bus.oStrobe_out && n < 300);

    if (idx == 6'd0) begin
      modelCount = 8'd0;
      strobeSeen = 0;
      for (int k = 0; k < RESP_DELAY + 3; k++) begin
        @(posedge iClock_host); #1;
        if (bus.oStrobe_out) strobeSeen++;
      end
      check("go_idle_no_response", strobeSeen, 0);
      return;
    end

    check("resp_strobe_latency", n, RESP_DELAY + 1);
    resp       = bus.oCmd_out;
    modelCount = nextCount;

    if (mode == 1) begin
      n = 0; sawComplete = 0;
      do begin
        @(posedge iClock_host); #1; n++;
        if (oCommand_complete) sawComplete = 1;
      end while (!oTimeout_error && n < 200);
      check("resp_stb_timeout_cycles", n, ACK_TIMEOUT);
      check("resp_stb_timeout_strobe", bus.oStrobe_out, 0);
      check("resp_stb_timeout_idle", oIdle_out, 1);
      check("resp_stb_timeout_nocomplete", sawComplete, 0);
      return;
    end

    for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
      @(posedge iClock_host); #1;
    end
    bus.iAck_in = 1'b1;
    n = 0;
    do begin @(posedge iClock_host); #1; n++; end while (bus.oStrobe_out && n < 20);
    check("resp_strobe_drop", n, 1);

    if (mode == 2) begin
      n = 0; sawComplete = 0;
      do begin
        @(posedge iClock_host); #1; n++;
        if (oCommand_complete) sawComplete = 1;
      end while (!oTimeout_error && n < 200);
      bus.iAck_in = 1'b0;
      check("resp_rel_timeout_cycles", n, ACK_TIMEOUT);
      check("resp_rel_timeout_idle", oIdle_out, 1);
      check("resp_rel_timeout_nocomplete", sawComplete, 0);
      return;
    end

    for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
      @(posedge iClock_host); #1;
    end
    bus.iAck_in = 1'b0;
    n = 0;
    do begin @(posedge iClock_host); #1; n++; end while (!oCommand_complete && n < 20);
    check("complete_latency", n, 1);
    check("complete_idle", oIdle_out, 1);
    check("index_error_held", oCommand_index_error, illegal);
    @(posedge iClock_host); #1;
    check("complete_single_pulse", oCommand_complete, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [37:0] r;
    logic [5:0]  rIdx;
    logic [31:0] rArg;
    int          m;
    int          mode;

    iReset         = 1'b1;
    bus.iStrobe_in = 1'b0;
    bus.iCmd_in    = '0;
    bus.iAck_in    = 1'b0;

    // Hand-computed pins for the CRC model (SD CMD0 / CMD8 frames, x^7, x^8).
    check("crc_model_x7", refCrc7(40'd1), 7'h09);
    check("crc_model_x8", refCrc7(40'd2), 7'h12);
    check("crc_model_cmd0", refCrc7(40'h40_0000_0000), 7'h4A);
    check("crc_model_cmd8", refCrc7(40'h48_0000_01AA), 7'h43);

    #12;
    check("reset_idle", oIdle_out, 1);
    check("reset_ack", bus.oAck_out, 0);
    check("reset_strobe", bus.oStrobe_out, 0);
    check("reset_cmd_out", bus.oCmd_out, 0);
    check("reset_complete", oCommand_complete, 0);
    check("reset_index_error", oCommand_index_error, 0);
    check("reset_timeout", oTimeout_error, 0);
    @(negedge iClock_host);
    iReset = 1'b0;
    @(posedge iClock_host); #1;

    // Directed sequence with literal expectations.
    runCmd(6'h3F, 32'd5, 0, r);
    check("lit_illegal_3f", r, {6'h3F, 16'h0005, 8'd0, 8'h01});
    runCmd(6'd17, 32'h0000_ABCD, 0, r);
    check("lit_legal_17", r, {6'd17, 16'hABCD, 8'd1, 8'h00});
    check("index_error_cleared", oCommand_index_error, 0);
    runCmd(6'd5, 32'h1234_5678, 0, r);
    check("lit_legal_5", r, {6'd5, 16'h5678, 8'd2, 8'h00});
    runCmd(6'd0, 32'h0000_00FF, 0, r);
    runCmd(6'd9, 32'h0000_0001, 0, r);
    check("lit_after_go_idle", r, {6'd9, 16'h0001, 8'd1, 8'h00});
    runCmd(6'd20, 32'h0000_A5A5, 1, r);
    check("lit_resp_stb_timeout", r, {6'd20, 16'hA5A5, 8'd2, 8'h00});
    runCmd(6'd21, 32'h0000_0F0F, 2, r);
    check("lit_resp_rel_timeout", r, {6'd21, 16'h0F0F, 8'd3, 8'h00});
    runCmd(6'd22, 32'h0000_0000, 3, r);

    // Reset while waiting NCR.
    bus.iCmd_in    = {6'd30, 32'h0000_0077};
    bus.iStrobe_in = 1'b1;
    @(posedge iClock_host); #1;
    check("rst_seq_ack", bus.oAck_out, 1);
    bus.iStrobe_in = 1'b0;
    @(posedge iClock_host); #1;
    check("rst_seq_ack_release", bus.oAck_out, 0);
    @(posedge iClock_host); #2;
    iReset = 1'b1;
    #1;
    check("midrst_idle", oIdle_out, 1);
    check("midrst_ack", bus.oAck_out, 0);
    check("midrst_strobe", bus.oStrobe_out, 0);
    check("midrst_cmd_out", bus.oCmd_out, 0);
    check("midrst_complete", oCommand_complete, 0);
    check("midrst_index_error", oCommand_index_error, 0);
    check("midrst_timeout", oTimeout_error, 0);
    @(negedge iClock_host);
    iReset     = 1'b0;
    modelCount = 8'd0;
    @(posedge iClock_host); #1;
    runCmd(6'd17, 32'h0000_ABCD, 0, r);
    check("lit_after_reset", r, {6'd17, 16'hABCD, 8'd1, 8'h00});

    // Index legality boundary.
    runCmd(6'd55, 32'h0000_0000, 0, r);
    check("lit_index_55_legal", r, {6'd55, 16'h0000, 8'd2, 8'h00});
    runCmd(6'd56, 32'h0000_0000, 0, r);
    check("lit_index_56_illegal", r, {6'd56, 16'h0000, 8'd2, 8'h01});

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      rIdx = 6'($urandom_range(0, 63));
      rArg = $urandom;
      m    = int'($urandom_range(0, 9));
      mode = (m <= 6) ? 0 : m - 6;
      runCmd(rIdx, rArg, mode, r);
    end

    // Counter wrap: 256 legal commands from a cleared counter.
    runCmd(6'd0, 32'h0, 0, r);
    for (int i = 0; i < 256; i++) begin
      rIdx = 6'($urandom_range(1, MAX_INDEX));
      rArg = $urandom;
      runCmd(rIdx, rArg, 0, r);
      if (i == 254) check("wrap_count_ff", r[15:8], 8'hFF);
      if (i == 255) check("wrap_count_00", r[15:8], 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
